// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with single-cycle logic/arith ops,
// shift-add multiply and restoring divide behind a start/ready/done handshake.
module ula_multiciclo #(
   parameter int DWIDTH     = 32,
   parameter bit SIGNED_CMP = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        opcode,
   input  logic [DWIDTH-1:0] operand_a,
   input  logic [DWIDTH-1:0] operand_b,
   output logic              ready,
   output logic              done,
   output logic [DWIDTH-1:0] result,
   output logic [DWIDTH-1:0] result_hi,
   output logic              below,
   output logic              equal,
   output logic              above,
   output logic              errorFlag
);
   localparam int SW = $clog2(DWIDTH);
   localparam int CW = SW + 1;
   localparam logic [3:0] OP_ADD = 4'd3, OP_SUB = 4'd4, OP_MUL = 4'd5, OP_DIV = 4'd6,
                          OP_AND = 4'd7, OP_OR = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10,
                          OP_CMP = 4'd11, OP_NOT = 4'd12;
   typedef enum logic [2:0] {IDLE, EXEC1, MUL_IT, DIV_IT, DONE} state_t;
   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [DWIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [DWIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DWIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
   logic              below_q, below_d, equal_q, equal_d, above_q, above_d, err_q, err_d;
   logic [DWIDTH:0]   mul_sum, div_sh, div_diff;
   logic              div_ge, lt, shift_big;
   // hi:lo holds partial product (MUL) or remainder:quotient (DIV)
   assign mul_sum   = lo_q[0] ? {1'b0, hi_q} + {1'b0, a_q} : {1'b0, hi_q};
   assign div_sh    = {hi_q, lo_q[DWIDTH-1]};
   assign div_diff  = div_sh - {1'b0, b_q};
   assign div_ge    = ~div_diff[DWIDTH];
   assign lt        = SIGNED_CMP ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
   assign shift_big = |b_q[DWIDTH-1:SW];
   assign ready     = (state_q == IDLE) || (state_q == DONE);
   assign done      = state_q == DONE;
   assign result    = res_q;
   assign result_hi = res_hi_q;
   assign below     = below_q;
   assign equal     = equal_q;
   assign above     = above_q;
   assign errorFlag = err_q;
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      below_d  = below_q;
      equal_d  = equal_q;
      above_d  = above_q;
      err_d    = err_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               op_d    = opcode;
               a_d     = operand_a;
               b_d     = operand_b;
               cnt_d   = '0;
               hi_d    = '0;
               lo_d    = (opcode == OP_MUL) ? operand_b : operand_a;
               state_d = (opcode == OP_MUL) ? MUL_IT :
                         (opcode == OP_DIV && operand_b != '0) ? DIV_IT : EXEC1;
            end
         end
         EXEC1: begin
            state_d  = DONE;
            err_d    = 1'b0;
            res_hi_d = '0;
            case (op_q)
               OP_ADD: res_d = a_q + b_q;
               OP_SUB: res_d = a_q - b_q;
               OP_AND: res_d = a_q & b_q;
               OP_OR:  res_d = a_q | b_q;
               OP_SHL: res_d = shift_big ? '0 : a_q << b_q[SW-1:0];
               OP_SHR: res_d = shift_big ? '0 : a_q >> b_q[SW-1:0];
               OP_NOT: res_d = ~a_q;
               OP_CMP: begin
                  res_d   = '0;
                  below_d = lt;
                  equal_d = a_q == b_q;
                  above_d = !lt && (a_q != b_q);
               end
               OP_DIV: begin
                  res_d    = '0;
                  res_hi_d = a_q;
                  err_d    = 1'b1;
               end
               default: begin
                  res_d = '0;
                  err_d = 1'b1;
               end
            endcase
         end
         MUL_IT, DIV_IT: begin
            if (cnt_q == CW'(DWIDTH)) begin
               state_d  = DONE;
               res_d    = lo_q;
               res_hi_d = hi_q;
               err_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (state_q == MUL_IT) {hi_d, lo_d} = {mul_sum, lo_q[DWIDTH-1:1]};
               else begin
                  hi_d = div_ge ? div_diff[DWIDTH-1:0] : div_sh[DWIDTH-1:0];
                  lo_d = {lo_q[DWIDTH-2:0], div_ge};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         res_hi_q <= '0;
         below_q  <= 1'b0;
         equal_q  <= 1'b0;
         above_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         below_q  <= below_d;
         equal_q  <= equal_d;
         above_q  <= above_d;
         err_q    <= err_d;
      end
   end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: table vectors, corner sequences and random ops against an arithmetic model.
module tb_ula_multiciclo;
   logic        clk = 1'b0, reset, start;
   logic [3:0]  opcode;
   logic [31:0] operand_a, operand_b;
   logic        ready, done, below, equal, above, errorFlag;
   logic [31:0] result, result_hi;
   logic        s_ready, s_done, s_below, s_equal, s_above, s_err;
   logic [31:0] s_result, s_hi;
   int          passed = 0, total = 0;
   logic        ub, ue, ua, sb, se, sa;
   always #5 clk = ~clk;
   ula_multiciclo #(.DWIDTH(32), .SIGNED_CMP(1'b0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .operand_a(operand_a), .operand_b(operand_b), .ready(ready), .done(done),
      .result(result), .result_hi(result_hi), .below(below), .equal(equal),
      .above(above), .errorFlag(errorFlag));
   ula_multiciclo #(.DWIDTH(32), .SIGNED_CMP(1'b1)) u_sdut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .operand_a(operand_a), .operand_b(operand_b), .ready(s_ready), .done(s_done),
      .result(s_result), .result_hi(s_hi), .below(s_below), .equal(s_equal),
      .above(s_above), .errorFlag(s_err));
   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, res, hi;
      logic        err;
   } vec_t;
   vec_t tbl[14];
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask
   // reference: plain arithmetic on the opcode meaning, flags persist between CMPs
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [31:0] h, output logic e);
      logic [63:0] p;
      r = 0; h = 0; e = 0;
      case (op)
         3: r = a + b;
         4: r = a - b;
         5: begin p = 64'(a) * 64'(b); r = p[31:0]; h = p[63:32]; end
         6: if (b == 0) begin h = a; e = 1; end else begin r = a / b; h = a % b; end
         7: r = a & b;
         8: r = a | b;
         9: r = (b >= 32) ? 0 : a << b;
         10: r = (b >= 32) ? 0 : a >> b;
         11: begin
            ub = a < b; ue = a == b; ua = a > b;
            sb = $signed(a) < $signed(b); se = a == b; sa = $signed(a) > $signed(b);
         end
         12: r = ~a;
         default: e = 1;
      endcase
   endtask
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj);
      logic [31:0] r, h;
      logic        e, held;
      int          cyc, lat;
      model(op, a, b, r, h, e);
      lat = (op == 5 || (op == 6 && b != 0)) ? 33 : 1;
      opcode = op; operand_a = a; operand_b = b; start = 1;
      @(posedge clk); #1;
      start = 0; opcode = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
      check("busy_after_accept", {ready, done, s_ready, s_done}, 0);
      cyc = 0; held = 1;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == inj) && !done;
         if (start) begin opcode = 5; operand_a = $urandom; operand_b = $urandom; end
         if (!done && ready) held = 0;
      end
      start = 0;
      check($sformatf("latency op%0d", op), {cyc, s_done}, {lat, 1'b1});
      check("ready_low_while_busy", held, 1);
      check($sformatf("result op%0d a=%0h b=%0h", op, a, b), {result, result_hi, errorFlag}, {r, h, e});
      check($sformatf("s_result op%0d", op), {s_result, s_hi, s_err}, {r, h, e});
      check("flags_unsigned", {below, equal, above}, {ub, ue, ua});
      check("flags_signed", {s_below, s_equal, s_above}, {sb, se, sa});
   endtask
   initial begin
      logic seen;
      {ub, ue, ua, sb, se, sa} = 0;
      tbl[0]  = '{11, 3, 9, 0, 0, 0};
      tbl[1]  = '{3, 5, 7, 12, 0, 0};
      tbl[2]  = '{5, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 1, 0};
      tbl[3]  = '{6, 100, 7, 14, 2, 0};
      tbl[4]  = '{6, 9, 0, 0, 9, 1};
      tbl[5]  = '{11, 32'hFFFF_FFFF, 1, 0, 0, 0};
      tbl[6]  = '{9, 1, 31, 32'h8000_0000, 0, 0};
      tbl[7]  = '{9, 1, 32, 0, 0, 0};
      tbl[8]  = '{0, 5, 5, 0, 0, 1};
      tbl[9]  = '{4, 3, 5, 32'hFFFF_FFFE, 0, 0};
      tbl[10] = '{12, 32'h0F0F_0F0F, 77, 32'hF0F0_F0F0, 0, 0};
      tbl[11] = '{10, 32'h8000_0000, 31, 1, 0, 0};
      tbl[12] = '{7, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, 0};
      tbl[13] = '{8, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF, 0, 0};
      reset = 1; start = 0; opcode = 0; operand_a = 0; operand_b = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {ready, done, result, result_hi, below, equal, above, errorFlag},
            {1'b1, 1'b0, 64'h0, 4'h0});
      check("reset_state_s", {s_ready, s_done, s_result, s_hi, s_below, s_equal, s_above, s_err},
            {1'b1, 1'b0, 64'h0, 4'h0});
      reset = 0;
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0);
         check($sformatf("table[%0d]", i), {result, result_hi, errorFlag},
               {tbl[i].res, tbl[i].hi, tbl[i].err});
      end
      check("cmp_neg1_vs_1", {below, above, s_below, s_above}, 4'b0110);
      @(posedge clk); #1;
      check("done_single_pulse", {ready, done}, 2'b10);
      run_op(5, 32'h0001_2345, 32'h0006_789A, 5);
      opcode = 5; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk); #1;
      {ub, ue, ua, sb, se, sa} = 0;
      check("reset_mid_mul", {ready, done, result, result_hi, below, equal, above, errorFlag},
            {1'b1, 1'b0, 64'h0, 4'h0});
      reset = 0; seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || s_done) seen = 1;
      end
      check("no_done_after_abort", seen, 0);
      for (int k = 0; k < 60; k++) begin
         logic [3:0]  op;
         logic [31:0] b;
         op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(3, 12));
         b  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom;
         run_op(op, $urandom, b, 0);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
         #0;
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
